line_mem_responder: RTL and testbench

//   Physical-memory responder for the mp2 cache: the memory end of the pmem interface the cache

---
 rtl/line_mem_responder_pkg.sv | 18 +
 rtl/line_mem_responder_array.sv | 38 +++
 rtl/line_mem_responder.sv | 159 +++++++++++++++
 tb/tb_line_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder_pkg
// Description : Shared types for the pmem line responder. Defines the
//               128-bit cache-line type, the 16-bit pmem byte-address type
//               and the number of in-line byte-offset address bits.
// Revision    : 1.0 - initial release
// ============================================================================
package line_mem_responder_pkg;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_pmem_addr;

    // Address bits [3:0] select a byte inside a 16-byte line.
    localparam int LINE_OFFSET_BITS = 4;

endpackage : line_mem_responder_pkg
`default_nettype wire

// File: rtl/line_mem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_array
// Description : 2**INDEX_BITS x 128-bit line storage. One synchronous write
//               port and one combinational read port. Contents are not reset.
// Ports       : clk       - clock
//               i_we      - write enable
//               i_windex  - write line index
//               i_wdata   - write line data
//               i_rindex  - read line index
//               o_rdata   - read line data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_array
    import line_mem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_windex,
    input  logic [127:0]          i_wdata,
    input  logic [INDEX_BITS-1:0] i_rindex,
    output logic [127:0]          o_rdata
);

    lc3b_line r_mem [0:(1<<INDEX_BITS)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_windex] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_rindex];

endmodule : line_mem_array
`default_nettype wire

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Memory end of the cache pmem interface. Accepts one line
//               read or write at a time, waits a programmable latency, then
//               pulses pmem_resp for one cycle. Reads return the line in the
//               pmem_resp cycle; writes commit to the array in that cycle.
//               Protocol violations raise a sticky protocol_err.
// Ports       : clk, reset_n (async, active low)
//               pmem_address - byte address, [3:0] ignored
//               pmem_read / pmem_write - level requests held until resp
//               pmem_wdata   - write line, sampled at acceptance
//               pmem_rdata   - registered read line, held until next read
//               pmem_resp    - one-cycle completion pulse
//               protocol_err - sticky violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter int INDEX_BITS    = 6,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         protocol_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam int c_TAG_LSB = LINE_OFFSET_BITS + INDEX_BITS;

    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(READ_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WRITE_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    lc3b_pmem_addr         r_addr;
    logic                  r_rd;
    logic                  r_wr;
    lc3b_line              r_wdata;
    lc3b_line              r_rdata;
    logic                  r_err;

    logic                  w_req;
    logic                  w_oor;
    logic [c_CNT_W-1:0]    w_load;
    logic [INDEX_BITS-1:0] w_req_index;
    logic [INDEX_BITS-1:0] w_cap_index;
    logic [INDEX_BITS-1:0] w_rindex;
    logic                  w_we;
    lc3b_line              w_arr_rdata;

    assign w_req       = pmem_read | pmem_write;
    // Upper address bits beyond the array are ignored (index wraps) but flagged.
    assign w_oor       = (pmem_address >> c_TAG_LSB) != 16'd0;
    // Simultaneous read+write is serviced as a write.
    assign w_load      = pmem_write ? c_WR_LOAD : c_RD_LOAD;
    assign w_req_index = pmem_address[LINE_OFFSET_BITS +: INDEX_BITS];
    assign w_cap_index = r_addr[LINE_OFFSET_BITS +: INDEX_BITS];
    // With a one-cycle latency the read data is loaded straight from IDLE,
    // before the address has been captured.
    assign w_rindex    = (r_state == c_ST_IDLE) ? w_req_index : w_cap_index;
    assign w_we        = (r_state == c_ST_RESP) && r_wr;

    line_mem_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk      (clk),
        .i_we     (w_we),
        .i_windex (w_cap_index),
        .i_wdata  (r_wdata),
        .i_rindex (w_rindex),
        .o_rdata  (w_arr_rdata)
    );

    // The counter holds the number of BUSY cycles still to come after the
    // current one; leaving BUSY when it reaches 1 places RESP exactly
    // LATENCY cycles after the request was first seen in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= pmem_address;
                        r_rd    <= pmem_read;
                        r_wr    <= pmem_write;
                        r_wdata <= pmem_wdata;
                        r_cnt   <= w_load;
                        if (w_load == '0) begin
                            r_state <= c_ST_RESP;
                            if (!pmem_write) begin
                                r_rdata <= w_arr_rdata;
                            end
                        end else begin
                            r_state <= c_ST_BUSY;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_ST_RESP;
                        if (!r_wr) begin
                            r_rdata <= w_arr_rdata;
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error: bad request shape at acceptance, or the request not held
    // stable (same op bits, same address) for the whole access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_req && ((pmem_read && pmem_write) || w_oor)) begin
                r_err <= 1'b1;
            end
        end else if ((pmem_read != r_rd) || (pmem_write != r_wr) ||
                     (pmem_address != r_addr)) begin
            r_err <= 1'b1;
        end
    end

    assign pmem_rdata   = r_rdata;
    assign pmem_resp    = (r_state == c_ST_RESP);
    assign protocol_err = r_err;

endmodule : line_mem_responder
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Self-checking bench for line_mem_responder. A driver issues
//               accesses and queues the expected response; a monitor pops
//               and compares on every pmem_resp. A second instance built
//               with READ_LATENCY=7 / WRITE_LATENCY=1 covers latency extremes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

    localparam int LAT = 4;
    localparam logic [127:0] c_DB  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [127:0] c_D0  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] c_D1  = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [127:0] c_D2  = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
    localparam logic [127:0] c_D3  = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
    localparam logic [127:0] c_D4  = 128'h0404_0404_0404_0404_0404_0404_0404_0404;
    localparam logic [127:0] c_D5  = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    localparam logic [127:0] c_DA  = 128'hA5A5_5A5A_A5A5_5A5A_0000_FFFF_1234_5678;
    localparam logic [127:0] c_L1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic         clk;
    logic         reset_n;
    logic [15:0]  addr;
    logic         rd;
    logic         wr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;
    logic         err;

    logic [15:0]  addr2;
    logic         rd2;
    logic         wr2;
    logic [127:0] wdata2;
    logic [127:0] rdata2;
    logic         resp2;
    logic         err2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           due;
        bit           is_read;
        logic [127:0] data;
        bit           err;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [127:0] hold = '0;
    bit           prev_resp = 0;
    logic [127:0] model [0:63];

    line_mem_responder #(
        .INDEX_BITS(6), .READ_LATENCY(4), .WRITE_LATENCY(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pmem_address(addr), .pmem_read(rd),
        .pmem_write(wr), .pmem_wdata(wdata), .pmem_rdata(rdata),
        .pmem_resp(resp), .protocol_err(err)
    );

    line_mem_responder #(
        .INDEX_BITS(6), .READ_LATENCY(7), .WRITE_LATENCY(1)
    ) dut_lat (
        .clk(clk), .reset_n(reset_n), .pmem_address(addr2), .pmem_read(rd2),
        .pmem_write(wr2), .pmem_wdata(wdata2), .pmem_rdata(rdata2),
        .pmem_resp(resp2), .protocol_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every response against the head of the scoreboard,
    // and checks pmem_rdata stays at the last read value between reads.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold      = '0;
            prev_resp = 0;
        end else begin
            if (resp) begin
                checks++;
                if (prev_resp) begin
                    errors++;
                    $display("FAIL resp_width: resp high on consecutive cycles at cyc %0d, required single cycle", cyc);
                end
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: resp=1 at cyc %0d, required no response", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.is_read) hold = mon_e.data;
                    checks++;
                    if (cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL resp_cycle: got %0d, required %0d", cyc, mon_e.due);
                    end
                    checks++;
                    if (err !== mon_e.err) begin
                        errors++;
                        $display("FAIL resp_err: got %0b, required %0b", err, mon_e.err);
                    end
                end
            end
            checks++;
            if (rdata !== hold) begin
                errors++;
                $display("FAIL rdata: got %h, required %h at cyc %0d", rdata, hold, cyc);
            end
            prev_resp = resp;
        end
    end

    // Wait (bounded) for resp on the main DUT, then drop the request in the
    // following cycle. Returns aligned one time unit after a rising edge.
    task automatic wait_resp();
        bit seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (resp) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: resp=0 after 30 cycles, required 1");
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic access(input bit r, input bit w, input logic [15:0] a,
                          input logic [127:0] d, input logic [127:0] exp_d,
                          input bit exp_err);
        exp_t e;
        rd = r; wr = w; addr = a; wdata = d;
        e.due = cyc + LAT; e.is_read = r & ~w; e.data = exp_d; e.err = exp_err;
        sbq.push_back(e);
        wait_resp();
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (resp !== 1'b0 || rdata !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: resp=%b err=%b rdata=%h, required all zero", tag, resp, err, rdata);
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 check_quiet("reset_outputs");
        rd = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_quiet("reset_held");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Direct latency check on the READ_LATENCY=7 / WRITE_LATENCY=1 instance.
    task automatic lat_access(input bit w, input logic [15:0] a, input logic [127:0] d,
                              input int exp_lat, input logic [127:0] exp_d);
        int  start;
        bit  seen = 0;
        rd2 = ~w; wr2 = w; addr2 = a; wdata2 = d;
        start = cyc;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (resp2) seen = 1;
        end
        checks++;
        if (!seen || (cyc - start) != exp_lat) begin
            errors++;
            $display("FAIL lat_cycles: got %0d (seen=%0b), required %0d", cyc - start, seen, exp_lat);
        end
        if (!w) begin
            checks++;
            if (rdata2 !== exp_d) begin
                errors++;
                $display("FAIL lat_rdata: got %h, required %h", rdata2, exp_d);
            end
        end
        @(posedge clk);
        #1;
        rd2 = 1'b0; wr2 = 1'b0;
        @(negedge clk);
        checks++;
        if (resp2 !== 1'b0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL lat_pulse: resp=%b err=%b after resp, required 0 0", resp2, err2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]   line;
        logic [127:0] d;
        reset_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
        repeat (3) @(posedge clk);
        #1 check_quiet("initial_reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a write aborts it.
        access(0, 1, 16'h0040, c_D0, '0, 0);
        rd = 1'b0; wr = 1'b1; addr = 16'h0040; wdata = c_D1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        access(1, 0, 16'h0040, '0, c_D0, 0);

        // Basic write/read, offset bits ignored.
        access(0, 1, 16'h0120, c_DB, '0, 0);
        access(1, 0, 16'h012A, '0, c_DB, 0);

        // Back-to-back write then read of the same line; later write
        // to another line must not disturb rdata.
        access(0, 1, 16'h0200, c_D3, '0, 0);
        access(0, 1, 16'h0200, c_D2, '0, 0);
        access(1, 0, 16'h0200, '0, c_D2, 0);
        access(0, 1, 16'h0210, c_D4, '0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Randomised traffic against a line model.
        for (int i = 0; i < 64; i++) begin
            line = 6'(i);
            d = {$urandom, $urandom, $urandom, $urandom};
            model[i] = d;
            access(0, 1, {6'd0, line, 4'(i)}, d, '0, 0);
        end
        for (int i = 0; i < 200; i++) begin
            line = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                model[line] = d;
                access(0, 1, {6'd0, line, 4'($urandom_range(0, 15))}, d, '0, 0);
            end else begin
                access(1, 0, {6'd0, line, 4'($urandom_range(0, 15))}, '0, model[line], 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL random_err: got %b, required 0", err);
        end

        // Violations: read+write together is a write; out-of-range wraps.
        access(1, 1, 16'h0080, c_D5, '0, 1);
        access(1, 0, 16'h0480, '0, c_D5, 1);
        do_reset();

        // Address change while BUSY: completes on the captured address.
        begin
            exp_t e;
            rd = 1'b0; wr = 1'b1; addr = 16'h0300; wdata = c_DA;
            e.due = cyc + LAT; e.is_read = 0; e.data = '0; e.err = 1;
            sbq.push_back(e);
            repeat (2) @(posedge clk);
            #1 addr = 16'h0310;
            wait_resp();
        end
        access(1, 0, 16'h0300, '0, c_DA, 1);

        // Latency extremes on the second instance.
        lat_access(1, 16'h0050, c_L1, 1, '0);
        lat_access(0, 16'h0050, '0, 7, c_L1);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_line_mem_responder
`default_nettype wire
